// File: rtl/core_pkg.sv
// Shared types and constants for the PC / control-transfer unit.
package core_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pcu_state_t;

    localparam int         ALU_TAKEN_BIT    = 30;
    localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational control-transfer decode: target mux, JALR bit-0 clear and
// alignment check. Priority JALR > JAL > taken branch.
module branch_target_calc
    import core_pkg::*;
(
    input  logic        is_branch_i,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_imm_i,
    input  logic [31:0] alu_out_i,
    output logic        transfer_o,
    output logic [31:0] target_o,
    output logic        misalign_o
);

    always_comb begin
        target_o   = ex_pc_i + ex_imm_i;
        transfer_o = 1'b0;
        if (is_jalr_i) begin
            target_o   = alu_out_i & ~32'h1;
            transfer_o = 1'b1;
        end else if (is_jal_i) begin
            transfer_o = 1'b1;
        end else if (is_branch_i && alu_out_i[ALU_TAKEN_BIT]) begin
            transfer_o = 1'b1;
        end
        misalign_o = |(target_o[1:0] & INSTR_ALIGN_MASK);
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC register, redirect/flush sequencer and misaligned-target trap.
// Optional branch statistics counters when BRANCH_STATS_EN is defined.
module branch_pc_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    parameter int          FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] alu_out,
    output logic [31:0] pc_out,
    output logic        if_valid,
    output logic        flush,
    output logic        redirect,
    output logic        misalign_trap,
    output logic [31:0] mtval
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_taken,
    output logic [31:0] stat_not_taken
`endif
);

    pcu_state_t  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mtval_q, mtval_d;
    logic        redirect_q, redirect_d;
    logic        trap_q, trap_d;

    logic        transfer;
    logic [31:0] target;
    logic        misalign;

    branch_target_calc u_target (
        .is_branch_i (ex_is_branch),
        .is_jal_i    (ex_is_jal),
        .is_jalr_i   (ex_is_jalr),
        .ex_pc_i     (ex_pc),
        .ex_imm_i    (ex_imm),
        .alu_out_i   (alu_out),
        .transfer_o  (transfer),
        .target_o    (target),
        .misalign_o  (misalign)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        mtval_d    = mtval_q;
        redirect_d = 1'b0;
        trap_d     = 1'b0;
        case (state_q)
            INIT: state_d = RUN;
            RUN: begin
                // A resolving transfer wins over a hazard stall.
                if (ex_valid && transfer) begin
                    state_d    = FLUSH;
                    cnt_d      = 3'(FLUSH_DEPTH - 1);
                    redirect_d = 1'b1;
                    if (misalign) begin
                        pc_d    = TRAP_VEC;
                        mtval_d = target;
                        trap_d  = 1'b1;
                    end else begin
                        pc_d = target;
                    end
                end else if (!stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            FLUSH: begin
                if (cnt_q == 3'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            cnt_q      <= 3'd0;
            pc_q       <= RESET_VEC;
            mtval_q    <= 32'h0;
            redirect_q <= 1'b0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            mtval_q    <= mtval_d;
            redirect_q <= redirect_d;
            trap_q     <= trap_d;
        end
    end

    assign pc_out        = pc_q;
    assign if_valid      = (state_q == RUN);
    assign flush         = (state_q == FLUSH);
    assign redirect      = redirect_q;
    assign misalign_trap = trap_q;
    assign mtval         = mtval_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken_q, stat_not_taken_q;
    logic        branch_sel;

    // Only a branch that is not overridden by JAL/JALR counts as a branch.
    assign branch_sel = ex_valid && (state_q == RUN) && ex_is_branch && !ex_is_jal && !ex_is_jalr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_taken_q     <= 32'h0;
            stat_not_taken_q <= 32'h0;
        end else if (branch_sel) begin
            if (alu_out[ALU_TAKEN_BIT]) stat_taken_q     <= stat_taken_q + 32'd1;
            else                        stat_not_taken_q <= stat_not_taken_q + 32'd1;
        end
    end

    assign stat_taken     = stat_taken_q;
    assign stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: vector table with a scoreboard
// queue, plus reset and reset-during-flush sequences.
module tb_branch_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int          FD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [31:0] ex_pc, ex_imm, alu_out;
    logic [31:0] pc_out, mtval;
    logic        if_valid, flush, redirect, misalign_trap;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken, stat_not_taken;
    int          m_taken = 0, m_not_taken = 0;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    branch_pc_unit #(.RESET_VEC(RV), .TRAP_VEC(TV), .FLUSH_DEPTH(FD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jal     (ex_is_jal),
        .ex_is_jalr    (ex_is_jalr),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .alu_out       (alu_out),
        .pc_out        (pc_out),
        .if_valid      (if_valid),
        .flush         (flush),
        .redirect      (redirect),
        .misalign_trap (misalign_trap),
        .mtval         (mtval)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken    (stat_taken),
        .stat_not_taken(stat_not_taken)
`endif
    );

    typedef struct {
        logic        stall, valid, br, jal, jalr;
        logic [31:0] pc, imm, alu;
        logic        e_redir, e_trap;
        logic [31:0] e_pc, e_mtval;
    } vec_t;

    typedef struct {
        logic        redir, trap;
        logic [31:0] pc, mtval;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];

    function automatic vec_t mk(logic st, logic v, logic b, logic j, logic jr,
                                logic [31:0] p, logic [31:0] im, logic [31:0] a,
                                logic er, logic et, logic [31:0] ep, logic [31:0] em);
        vec_t r;
        r.stall = st; r.valid = v; r.br = b; r.jal = j; r.jalr = jr;
        r.pc = p; r.imm = im; r.alu = a;
        r.e_redir = er; r.e_trap = et; r.e_pc = ep; r.e_mtval = em;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic idle_inputs();
        stall = 0; ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_pc = 0; ex_imm = 0; alu_out = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        // stall valid br jal jalr  ex_pc  ex_imm  alu  | redir trap pc mtval
        vecs[0]  = mk(0,1,1,0,0, 32'h10,   32'h40,       32'h0,         0,0, 32'h0C,       32'h0);
        vecs[1]  = mk(0,1,1,0,0, 32'h10,   32'h40,       32'hBFFF_FFFF, 0,0, 32'h10,       32'h0);
        vecs[2]  = mk(0,1,1,0,0, 32'h20,   32'h40,       32'h4000_0000, 1,0, 32'h60,       32'h0);
        vecs[3]  = mk(1,0,0,0,0, 32'h0,    32'h0,        32'h0,         0,0, 32'h60,       32'h0);
        vecs[4]  = mk(1,0,0,1,0, 32'h0,    32'h8,        32'h0,         0,0, 32'h60,       32'h0);
        vecs[5]  = mk(0,0,0,0,0, 32'h0,    32'h0,        32'h0,         0,0, 32'h64,       32'h0);
        vecs[6]  = mk(0,1,0,0,1, 32'h64,   32'h0,        32'h1235,      1,0, 32'h1234,     32'h0);
        vecs[7]  = mk(0,1,0,0,1, 32'h1234, 32'h0,        32'h1236,      1,1, 32'h100,      32'h1236);
        vecs[8]  = mk(0,1,1,0,0, 32'h200,  32'hFFFF_FFF0, 32'h4000_0000, 1,0, 32'h1F0,      32'h1236);
        vecs[9]  = mk(1,1,0,1,0, 32'h40,   32'h40,       32'h0,         1,0, 32'h80,       32'h1236);
        vecs[10] = mk(0,1,1,1,1, 32'h500,  32'h4,        32'h3000,      1,0, 32'h3000,     32'h1236);
        vecs[11] = mk(0,1,1,1,0, 32'h1000, 32'h2,        32'h4000_0000, 1,1, 32'h100,      32'h1002);
        vecs[12] = mk(0,1,1,0,0, 32'h10,   32'h1,        32'h4000_0000, 1,1, 32'h100,      32'h11);
        vecs[13] = mk(0,0,0,0,0, 32'h0,    32'h0,        32'h0,         0,0, 32'h104,      32'h11);
        vecs[14] = mk(0,1,0,1,0, 32'h0,    32'hFFFF_FFF8, 32'h0,         1,0, 32'hFFFF_FFF8, 32'h11);
        vecs[15] = mk(0,0,0,0,0, 32'h0,    32'h0,        32'h0,         0,0, 32'hFFFF_FFFC, 32'h11);
        vecs[16] = mk(0,0,0,0,0, 32'h0,    32'h0,        32'h0,         0,0, 32'h0,        32'h11);

        rst_n = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_out, RV);
        chk("rst_if_valid", {31'b0, if_valid}, 0);
        chk("rst_flush", {31'b0, flush}, 0);
        chk("rst_redirect", {31'b0, redirect}, 0);
        chk("rst_trap", {31'b0, misalign_trap}, 0);
        chk("rst_mtval", mtval, 0);
`ifdef BRANCH_STATS_EN
        chk("rst_stat_taken", stat_taken, 0);
        chk("rst_stat_not_taken", stat_not_taken, 0);
`endif

        @(negedge clk) rst_n = 1;
        #1 chk("init_if_valid", {31'b0, if_valid}, 0);
        @(posedge clk) #1;
        chk("run0_if_valid", {31'b0, if_valid}, 1);
        chk("run0_pc", pc_out, 32'h0);
        @(posedge clk) #1 chk("run1_pc", pc_out, 32'h4);
        @(posedge clk) #1 chk("run2_pc", pc_out, 32'h8);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            stall = vecs[i].stall; ex_valid = vecs[i].valid;
            ex_is_branch = vecs[i].br; ex_is_jal = vecs[i].jal; ex_is_jalr = vecs[i].jalr;
            ex_pc = vecs[i].pc; ex_imm = vecs[i].imm; alu_out = vecs[i].alu;
            e.redir = vecs[i].e_redir; e.trap = vecs[i].e_trap;
            e.pc = vecs[i].e_pc; e.mtval = vecs[i].e_mtval;
            sb.push_back(e);
`ifdef BRANCH_STATS_EN
            if (vecs[i].valid && vecs[i].br && !vecs[i].jal && !vecs[i].jalr) begin
                if (vecs[i].alu[30]) m_taken++;
                else                 m_not_taken++;
            end
`endif
            @(posedge clk) #1;
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_redirect", i), {31'b0, redirect}, {31'b0, e.redir});
                chk($sformatf("v%0d_trap", i), {31'b0, misalign_trap}, {31'b0, e.trap});
                chk($sformatf("v%0d_pc", i), pc_out, e.pc);
                chk($sformatf("v%0d_mtval", i), mtval, e.mtval);
                chk($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, e.redir});
                chk($sformatf("v%0d_if_valid", i), {31'b0, if_valid}, {31'b0, !e.redir});
                if (e.redir) begin
                    // EX inputs stay asserted through the flush; they must be ignored.
                    for (int k = 1; k < FD; k++) begin
                        @(posedge clk) #1;
                        chk($sformatf("v%0d_flush_hold", i), {31'b0, flush}, 1);
                        chk($sformatf("v%0d_redirect_pulse", i), {31'b0, redirect}, 0);
                        chk($sformatf("v%0d_trap_pulse", i), {31'b0, misalign_trap}, 0);
                        chk($sformatf("v%0d_pc_hold", i), pc_out, e.pc);
                    end
                    @(posedge clk) #1;
                    chk($sformatf("v%0d_flush_end", i), {31'b0, flush}, 0);
                    chk($sformatf("v%0d_if_valid_back", i), {31'b0, if_valid}, 1);
                    chk($sformatf("v%0d_pc_target", i), pc_out, e.pc);
                end
            end
        end
        @(negedge clk) idle_inputs();

`ifdef BRANCH_STATS_EN
        chk("stat_taken", stat_taken, 32'(m_taken));
        chk("stat_not_taken", stat_not_taken, 32'(m_not_taken));
`endif

        // Reset asserted during the first flush cycle.
        @(negedge clk);
        ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h40; ex_imm = 32'h40;
        @(posedge clk) #1;
        chk("mf_flush", {31'b0, flush}, 1);
        chk("mf_pc", pc_out, 32'h80);
        #2 rst_n = 0;
        #1;
        chk("mf_rst_flush", {31'b0, flush}, 0);
        chk("mf_rst_pc", pc_out, RV);
        chk("mf_rst_if_valid", {31'b0, if_valid}, 0);
        chk("mf_rst_redirect", {31'b0, redirect}, 0);
        chk("mf_rst_mtval", mtval, 0);
        idle_inputs();
        @(negedge clk) rst_n = 1;
        #1;
        chk("mf_init_if_valid", {31'b0, if_valid}, 0);
        chk("mf_init_flush", {31'b0, flush}, 0);
        @(posedge clk) #1;
        chk("mf_run_if_valid", {31'b0, if_valid}, 1);
        chk("mf_run_pc", pc_out, RV);
        @(posedge clk) #1;
        chk("mf_run_pc_inc", pc_out, RV + 32'd4);
        chk("mf_run_no_flush", {31'b0, flush}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
